// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC holder and instruction-memory front end feeding the decode
//            stage. It presents one instruction per cycle, holds it across
//            decode stalls and squashes in-flight fetches on a taken branch.
// Options  : define FETCH_PERF_EN to add saturating fetch/squash counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instruction_fetch,
    output logic [PC_W-1:0]    pc_fetch,
    output logic               valid_fetch
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_count_o,
    output logic [15:0]        squash_count_o
`endif
);

    logic [PC_W-1:0]    r_pc;
    logic               r_pend;
    logic [PC_W-1:0]    r_pend_pc;
    logic               r_hold_v;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [PC_W-1:0]    r_hold_pc;
    logic               w_issue;

    assign w_issue     = rst_n & ~stall_i & ~redirect_i;
    assign imem_req_o  = w_issue;
    assign imem_addr_o = r_pc;

    // The hold buffer wins over the memory response; a redirect blanks both.
    always_comb begin
        instruction_fetch = NOP_INSTR;
        pc_fetch          = '0;
        valid_fetch       = 1'b0;
        if (!redirect_i) begin
            if (r_hold_v) begin
                instruction_fetch = r_hold_instr;
                pc_fetch          = r_hold_pc;
                valid_fetch       = 1'b1;
            end else if (r_pend) begin
                instruction_fetch = imem_rdata_i;
                pc_fetch          = r_pend_pc;
                valid_fetch       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= '0;
            r_hold_v     <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= '0;
        end else if (redirect_i) begin
            r_pc     <= redirect_pc_i;
            r_pend   <= 1'b0;
            r_hold_v <= 1'b0;
        end else if (!stall_i) begin
            // Any held instruction is consumed this cycle, so the PC can advance.
            r_pc      <= r_pc + 1'b1;
            r_pend    <= 1'b1;
            r_pend_pc <= r_pc;
            r_hold_v  <= 1'b0;
        end else begin
            r_pend <= 1'b0;
            if (r_pend && !r_hold_v) begin
                r_hold_v     <= 1'b1;
                r_hold_instr <= imem_rdata_i;
                r_hold_pc    <= r_pend_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(r_pend && r_hold_v));
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_squash_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count  <= 16'h0000;
            r_squash_count <= 16'h0000;
        end else begin
            if (valid_fetch && !stall_i && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'h0001;
            end
            if (redirect_i && (r_pend || r_hold_v) && (r_squash_count != 16'hFFFF)) begin
                r_squash_count <= r_squash_count + 16'h0001;
            end
        end
    end

    assign fetch_count_o  = r_fetch_count;
    assign squash_count_o = r_squash_count;
`endif

endmodule
`default_nettype wire
